encrypt_pipe_ctrl: RTL and testbench

Sequencing controller for the encrypt/decrypt pipeline. It accepts one job configuration (three 8-bit keys, rotation frequency, mode, shift enable, message length), then streams message characters into the first pipeline stage under a valid/ready handshake. It applies a key-rotation schedule every `rot_freq` characters and drains the pipeline with bubble beats. It signals job completion with a `done` pulse and sits directly in front of the data-compare/shift stage.

---
 rtl/enc_pipe_pkg.sv | 40 ++++
 rtl/enc_ctrl_rot_sched.sv | 63 ++++++
 rtl/encrypt_pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_encrypt_pipe_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pipe_pkg.sv
// enc_pipe_pkg -- shared types for the encrypt/decrypt pipeline controller.
//   KEY_W / ROT_W : key and rotation-frequency widths
//   ctrl_state_e  : controller FSM states
//   enc_cfg_t     : latched job configuration (keys, rot_freq, mode, shift_en)
//   rot_keys()    : view of the job keys after a given number of rotations
package enc_pipe_pkg;

  localparam int KEY_W = 8;
  localparam int ROT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [KEY_W-1:0] k1;
    logic [KEY_W-1:0] k2;
    logic [KEY_W-1:0] k3;
    logic [ROT_W-1:0] rot_freq;
    logic             mode;
    logic             shift_en;
  } enc_cfg_t;

  // One rotation is k1<-k2, k2<-k3, k3<-k1, so after three the keys are back
  // where they started; sel is the rotation count modulo 3.
  function automatic enc_cfg_t rot_keys(enc_cfg_t c, logic [1:0] sel);
    enc_cfg_t r;
    r = c;
    case (sel)
      2'd1: begin r.k1 = c.k2; r.k2 = c.k3; r.k3 = c.k1; end
      2'd2: begin r.k1 = c.k3; r.k2 = c.k1; r.k3 = c.k2; end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/enc_ctrl_rot_sched.sv
// enc_ctrl_rot_sched -- key-rotation schedule for encrypt_pipe_ctrl.
// Only exists when ENC_CTRL_ROT_EN is defined; without it the controller
// keeps the configured keys and never raises shift_amt.
// Ports:
//   clk, rst        : clock, async active-low reset
//   load            : job configuration accepted this cycle (clears schedule)
//   rot_freq        : latched characters-per-rotation, 0 = no rotation
//   char_beat       : a message character is accepted this cycle
//   drain_beat      : a drain bubble is issued this cycle
//   rot_sel         : rotation count (mod 3) the current output beat uses
//   shift_amt       : registered shift flag for the current output beat
`ifdef ENC_CTRL_ROT_EN
module enc_ctrl_rot_sched
  import enc_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ROT_W-1:0] rot_freq,
  input  logic             char_beat,
  input  logic             drain_beat,
  output logic [1:0]       rot_sel,
  output logic             shift_amt
);

  logic [ROT_W-1:0] grp_cnt;
  // Rotation index for the *next* character. rot_sel only follows it on a
  // character beat, so the group-completing character still leaves with the
  // old keys and the rotated set shows up on the following beat.
  logic [1:0]       pend_sel;
  logic             grp_end;

  assign grp_end = (rot_freq != '0) && (grp_cnt == rot_freq - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp_cnt   <= '0;
      pend_sel  <= '0;
      rot_sel   <= '0;
      shift_amt <= 1'b0;
    end else if (load) begin
      grp_cnt   <= '0;
      pend_sel  <= '0;
      rot_sel   <= '0;
      shift_amt <= 1'b0;
    end else if (char_beat) begin
      rot_sel   <= pend_sel;
      shift_amt <= grp_end;
      if (rot_freq != '0) begin
        if (grp_end) begin
          grp_cnt  <= '0;
          pend_sel <= (pend_sel == 2'd2) ? 2'd0 : pend_sel + 1'b1;
        end else begin
          grp_cnt  <= grp_cnt + 1'b1;
        end
      end
    end else if (drain_beat) begin
      shift_amt <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/encrypt_pipe_ctrl.sv
// encrypt_pipe_ctrl -- sequencing controller for the encrypt/decrypt pipeline.
// Accepts one job configuration, streams cfg_len characters into the first
// pipeline stage, then flushes PIPE_DEPTH bubble beats and pulses done.
// Optional feature macro: ENC_CTRL_ROT_EN (key rotation + shift_amt).
// Ports:
//   clk, rst                 : clock, async active-low reset
//   cfg_valid / cfg_ready    : job configuration handshake (idle only)
//   cfg_k1..3, cfg_rot_freq, cfg_mode, cfg_shift_en, cfg_len : job fields
//   s_valid / s_ready, s_data: character stream in
//   out_ready                : downstream may advance; low freezes the pipe
//   en, din                  : pipeline advance strobe and character
//   k1..3, rot_freq, mode, shift_en, shift_amt : stage controls
//   busy                     : job in RUN or DRAIN
//   done                     : one-cycle job completion pulse
// PIPE_DEPTH must be at least 1.
module encrypt_pipe_ctrl
  import enc_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [KEY_W-1:0] cfg_k1,
  input  logic [KEY_W-1:0] cfg_k2,
  input  logic [KEY_W-1:0] cfg_k3,
  input  logic [ROT_W-1:0] cfg_rot_freq,
  input  logic             cfg_mode,
  input  logic             cfg_shift_en,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             out_ready,
  output logic             en,
  output logic [7:0]       din,
  output logic [KEY_W-1:0] k1,
  output logic [KEY_W-1:0] k2,
  output logic [KEY_W-1:0] k3,
  output logic [ROT_W-1:0] rot_freq,
  output logic             shift_en,
  output logic             shift_amt,
  output logic             mode,
  output logic             busy,
  output logic             done
);

  localparam int            DW         = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH);

  ctrl_state_e      state;
  enc_cfg_t         cfg_q;
  enc_cfg_t         key_view;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] char_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [1:0]       rot_sel;
  logic             cfg_fire;
  logic             char_beat;
  logic             drain_beat;
  logic             last_char;

  assign cfg_fire   = (state == IDLE) && cfg_valid && cfg_ready;
  assign s_ready    = (state == RUN) && out_ready;
  assign char_beat  = s_ready && s_valid;
  assign drain_beat = (state == DRAIN) && out_ready && (drain_cnt != DRAIN_LAST);
  assign last_char  = (char_cnt == len_q - 1'b1);

  // Stage controls come straight from the latched config, so they only move
  // on a config load or a character beat and hold across stalls.
  assign key_view = rot_keys(cfg_q, rot_sel);
  assign k1       = key_view.k1;
  assign k2       = key_view.k2;
  assign k3       = key_view.k3;
  assign rot_freq = cfg_q.rot_freq;
  assign mode     = cfg_q.mode;
  assign shift_en = cfg_q.shift_en;

`ifdef ENC_CTRL_ROT_EN
  enc_ctrl_rot_sched u_rot (
    .clk        (clk),
    .rst        (rst),
    .load       (cfg_fire),
    .rot_freq   (cfg_q.rot_freq),
    .char_beat  (char_beat),
    .drain_beat (drain_beat),
    .rot_sel    (rot_sel),
    .shift_amt  (shift_amt)
  );
`else
  assign rot_sel   = 2'd0;
  assign shift_amt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cfg_q     <= '0;
      len_q     <= '0;
      char_cnt  <= '0;
      drain_cnt <= '0;
      en        <= 1'b0;
      din       <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_fire) begin
            cfg_q.k1       <= cfg_k1;
            cfg_q.k2       <= cfg_k2;
            cfg_q.k3       <= cfg_k3;
            cfg_q.rot_freq <= cfg_rot_freq;
            cfg_q.mode     <= cfg_mode;
            cfg_q.shift_en <= cfg_shift_en;
            len_q          <= cfg_len;
            char_cnt       <= '0;
            drain_cnt      <= '0;
            cfg_ready      <= 1'b0;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (char_beat) begin
            en       <= 1'b1;
            din      <= s_data;
            char_cnt <= char_cnt + 1'b1;
            if (last_char) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_beat) begin
            en        <= 1'b1;
            din       <= 8'h00;
            drain_cnt <= drain_cnt + 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            // Waiting one cycle here puts done after the last bubble beat
            // rather than on top of it.
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt_pipe_ctrl.sv
module tb_encrypt_pipe_ctrl;
  localparam int PIPE_DEPTH = 4;
  localparam int LEN_W      = 16;
`ifdef ENC_CTRL_ROT_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, cfg_mode, cfg_shift_en;
  logic [7:0] cfg_k1, cfg_k2, cfg_k3;
  logic [2:0] cfg_rot_freq;
  logic [LEN_W-1:0] cfg_len;
  logic s_valid, s_ready, out_ready, en, shift_en, shift_amt, mode, busy, done;
  logic [7:0] s_data, din, k1, k2, k3;
  logic [2:0] rot_freq;

  always #5 clk = ~clk;

  encrypt_pipe_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_k3(cfg_k3),
    .cfg_rot_freq(cfg_rot_freq), .cfg_mode(cfg_mode), .cfg_shift_en(cfg_shift_en),
    .cfg_len(cfg_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .out_ready(out_ready), .en(en), .din(din),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq),
    .shift_en(shift_en), .shift_amt(shift_amt), .mode(mode),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0] din;
    logic       sh;
    logic [7:0] a, b, c;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  beat_t cb, la;
  int checks = 0;
  int errors = 0;
  logic [7:0] msg [0:15];
  logic [7:0] cur_a, cur_b, cur_c;
  logic [2:0] cur_rf;
  logic cur_mode, cur_sen;
  logic zl_expect = 1'b0;
  logic prev_final = 1'b0;
  logic or_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (bound expired) t=%0t", name, $time);
  endtask

  // Expected beat list for a whole job, from the rules: character i (1-based)
  // uses keys rotated floor((i-1)/rf) times and carries shift when i%rf==0.
  task automatic model_job(input logic [7:0] a, b, c, input int rf, input int len);
    beat_t nb;
    int r;
    nb.a = a; nb.b = b; nb.c = c;
    for (int i = 1; i <= len; i++) begin
      r = 0;
      nb.sh = 1'b0;
      if (ROT && rf != 0) begin
        r = ((i - 1) / rf) % 3;
        nb.sh = (i % rf == 0);
      end
      nb.din = msg[i-1];
      case (r)
        0:       begin nb.a = a; nb.b = b; nb.c = c; end
        1:       begin nb.a = b; nb.b = c; nb.c = a; end
        default: begin nb.a = c; nb.b = a; nb.c = b; end
      endcase
      nb.last = 1'b0;
      exp_q.push_back(nb);
    end
    if (len > 0) begin
      for (int j = 0; j < PIPE_DEPTH; j++) begin
        nb.din  = 8'h00;
        nb.sh   = 1'b0;
        nb.last = (j == PIPE_DEPTH - 1);
        exp_q.push_back(nb);
      end
    end
  endtask

  task automatic do_cfg(input logic [7:0] a, b, c, input logic [2:0] rf,
                        input logic md, sen, input int len);
    bit ok;
    ok = 1'b0;
    model_job(a, b, c, int'(rf), len);
    cfg_k1 = a; cfg_k2 = b; cfg_k3 = c;
    cfg_rot_freq = rf; cfg_mode = md; cfg_shift_en = sen;
    cfg_len = len[LEN_W-1:0];
    cfg_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("cfg_ready_wait");
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cur_a = a; cur_b = b; cur_c = c;
    cur_rf = rf; cur_mode = md; cur_sen = sen;
    log_q.delete();
    if (len == 0) zl_expect = 1'b1;
    chk("cfg_ready_drop", cfg_ready, 0);
    chk("busy_after_cfg", busy, len != 0);
  endtask

  task automatic send_chars(input int first, input int n);
    bit acc;
    for (int i = first; i < first + n; i++) begin
      acc = 1'b0;
      s_valid = 1'b1;
      s_data = msg[i];
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) fail_now("s_ready_wait");
    end
    s_valid = 1'b0;
  endtask

  task automatic stall(input int n);
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("done_wait");
    @(posedge clk);
    #1;
    chk("cfg_ready_return", cfg_ready, 1);
    chk("busy_after_done", busy, 0);
    chk("model_drained", exp_q.size(), 0);
  endtask

  // Compare process: every cycle out of reset, done/en/stall behaviour and
  // every beat's contents against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      prev_final = 1'b0;
      or_prev = 1'b1;
    end else begin
      chk("done", done, prev_final | zl_expect);
      zl_expect = 1'b0;
      prev_final = 1'b0;
      if (!or_prev) chk("stall_no_en", en, 0);
      if (en) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_en");
        end else begin
          cb = exp_q.pop_front();
          chk("din", din, cb.din);
          chk("shift_amt", shift_amt, cb.sh);
          chk("k1", k1, cb.a);
          chk("k2", k2, cb.b);
          chk("k3", k3, cb.c);
          chk("mode", mode, cur_mode);
          chk("shift_en", shift_en, cur_sen);
          chk("rot_freq", rot_freq, cur_rf);
          cur_a = cb.a; cur_b = cb.b; cur_c = cb.c;
          prev_final = cb.last;
          la.din = din; la.sh = shift_amt; la.a = k1; la.b = k2; la.c = k3;
          la.last = cb.last;
          log_q.push_back(la);
        end
      end
      if (!out_ready) begin
        chk("stall_s_ready", s_ready, 0);
        chk("stall_k1", k1, cur_a);
        chk("stall_k3", k3, cur_c);
        chk("stall_mode", mode, cur_mode);
      end
      or_prev = out_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nbub;
    rst = 1'b0;
    cfg_valid = 1'b0; cfg_k1 = 0; cfg_k2 = 0; cfg_k3 = 0; cfg_rot_freq = 0;
    cfg_mode = 0; cfg_shift_en = 0; cfg_len = 0;
    s_valid = 1'b0; s_data = 0; out_ready = 1'b1;
    cur_a = 0; cur_b = 0; cur_c = 0; cur_rf = 0; cur_mode = 0; cur_sen = 0;

    // Reset state
    #3;
    chk("rst_en", en, 0);
    chk("rst_din", din, 0);
    chk("rst_keys", {k1, k2, k3}, 0);
    chk("rst_ctrl", {rot_freq, shift_en, shift_amt, mode}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("cfg_ready_after_rst", cfg_ready, 1);
    chk("s_ready_idle", s_ready, 0);

    // Basic job
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
    do_cfg(8'h01, 8'h02, 8'h03, 3'd0, 1'b1, 1'b1, 3);
    send_chars(0, 3);
    wait_done();
    chk("basic_beats", log_q.size(), 7);
    chk("basic_din0", log_q[0].din, 8'h41);
    chk("basic_din2", log_q[2].din, 8'h43);
    chk("basic_bubble", log_q[3].din, 8'h00);
    chk("basic_keys", {log_q[2].a, log_q[2].b, log_q[2].c}, 24'h010203);

    // Rotation
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h64; msg[4] = 8'h65;
    do_cfg(8'h01, 8'h02, 8'h03, 3'd2, 1'b0, 1'b1, 5);
    send_chars(0, 5);
    wait_done();
    chk("rot_beats", log_q.size(), 9);
    chk("rot_sh1", log_q[0].sh, 0);
    chk("rot_sh2", log_q[1].sh, ROT);
    chk("rot_sh3", log_q[2].sh, 0);
    chk("rot_sh4", log_q[3].sh, ROT);
    chk("rot_keys2", {log_q[1].a, log_q[1].b, log_q[1].c}, 24'h010203);
    chk("rot_keys3", {log_q[2].a, log_q[2].b, log_q[2].c}, ROT ? 24'h020301 : 24'h010203);
    chk("rot_keys4", {log_q[3].a, log_q[3].b, log_q[3].c}, ROT ? 24'h020301 : 24'h010203);
    chk("rot_keys5", {log_q[4].a, log_q[4].b, log_q[4].c}, ROT ? 24'h030102 : 24'h010203);

    // Backpressure mid-stream and during drain
    msg[0] = 8'hA0; msg[1] = 8'hA1; msg[2] = 8'hA2; msg[3] = 8'hA3; msg[4] = 8'hA4;
    do_cfg(8'h5A, 8'h6B, 8'h7C, 3'd1, 1'b1, 1'b0, 5);
    send_chars(0, 2);
    s_valid = 1'b1;
    s_data = msg[2];
    stall(3);
    send_chars(2, 3);
    @(posedge clk);
    #1;
    stall(3);
    wait_done();
    chk("bp_beats", log_q.size(), 9);
    nbub = 0;
    foreach (log_q[i]) if (log_q[i].din == 8'h00) nbub++;
    chk("bp_drain_beats", nbub, 4);

    // Zero length
    do_cfg(8'h11, 8'h22, 8'h33, 3'd0, 1'b0, 1'b0, 0);
    wait_done();
    chk("zl_no_en", log_q.size(), 0);

    // Reset mid-job
    msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h35;
    do_cfg(8'h01, 8'h02, 8'h03, 3'd2, 1'b1, 1'b1, 5);
    send_chars(0, 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_en", en, 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_keys", {k1, k2, k3}, 0);
    chk("mid_rst_ctrl", {rot_freq, shift_en, shift_amt, mode}, 0);
    chk("mid_rst_busy_done", {busy, done}, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cfg_ready", cfg_ready, 1);
    chk("post_rst_done", done, 0);
    msg[0] = 8'h51; msg[1] = 8'h52;
    do_cfg(8'h0A, 8'h0B, 8'h0C, 3'd0, 1'b1, 1'b0, 2);
    send_chars(0, 2);
    wait_done();
    chk("post_rst_beats", log_q.size(), 6);

    // Config while busy is ignored
    msg[0] = 8'h71; msg[1] = 8'h72; msg[2] = 8'h73; msg[3] = 8'h74;
    do_cfg(8'h11, 8'h22, 8'h33, 3'd0, 1'b0, 1'b0, 4);
    send_chars(0, 1);
    cfg_valid = 1'b1;
    cfg_k1 = 8'hAA; cfg_k2 = 8'hBB; cfg_k3 = 8'hCC; cfg_len = 16'd2;
    cfg_mode = 1'b1; cfg_shift_en = 1'b1; cfg_rot_freq = 3'd3;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("cfg_ready_busy", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    send_chars(1, 3);
    wait_done();
    chk("busy_cfg_beats", log_q.size(), 8);
    chk("busy_cfg_keys", {log_q[3].a, log_q[3].b, log_q[3].c}, 24'h112233);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
